// File: rtl/ps2_keycode_packer.sv
// PS/2 scan-code set 2 receiver that keeps four held-key HID usage codes
// packed into a 32-bit word for the tank movement and fire logic.
module ps2_keycode_packer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keycode,
    output logic        key_event,
    output logic        frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state;
    logic             clk_s1, clk_s2, clk_prev;
    logic             data_s1, data_s2;
    logic             fall;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_bit;
    logic [CNT_W-1:0] timeout_cnt;
    logic             byte_valid;
    logic             ext, brk;
    logic [7:0]       hid;
    logic             mapped;
    logic             present;
    logic             placed;
    logic [31:0]      next_keycode;

    // Synchronizers reset to the idle-high line level so reset release never fakes an edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_state    <= RX_IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
            byte_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                timeout_cnt <= '0;
                case (rx_state)
                    RX_IDLE: begin
                        if (!data_s2) begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shift_reg <= {data_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) rx_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        parity_bit <= data_s2;
                        rx_state   <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (data_s2 && (^{shift_reg, parity_bit})) byte_valid <= 1'b1;
                        else                                         frame_err  <= 1'b1;
                        rx_state <= RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end else if (rx_state != RX_IDLE) begin
                if (timeout_cnt == TIMEOUT_MAX) begin
                    rx_state    <= RX_IDLE;
                    frame_err   <= 1'b1;
                    timeout_cnt <= '0;
                end else begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hid = 8'h00;
        case ({ext, shift_reg})
            9'h01C:  hid = 8'h04;
            9'h023:  hid = 8'h07;
            9'h01B:  hid = 8'h16;
            9'h01D:  hid = 8'h1A;
            9'h029:  hid = 8'h2C;
            9'h05A:  hid = 8'h28;
            9'h175:  hid = 8'h52;
            9'h172:  hid = 8'h51;
            9'h16B:  hid = 8'h50;
            9'h174:  hid = 8'h4F;
            default: hid = 8'h00;
        endcase
        mapped = (hid != 8'h00);
    end

    // Presses fill the lowest empty slot; releases blank their slot in place without compaction.
    always_comb begin
        next_keycode = keycode;
        present      = 1'b0;
        placed       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keycode[i*8 +: 8] == hid) present = 1'b1;
        end
        if (mapped && !brk && !present) begin
            for (int i = 0; i < 4; i++) begin
                if (!placed && keycode[i*8 +: 8] == 8'h00) begin
                    next_keycode[i*8 +: 8] = hid;
                    placed = 1'b1;
                end
            end
        end else if (mapped && brk) begin
            for (int i = 0; i < 4; i++) begin
                if (keycode[i*8 +: 8] == hid) next_keycode[i*8 +: 8] = 8'h00;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            keycode   <= 32'h0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid) begin
                if (shift_reg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext       <= 1'b0;
                    brk       <= 1'b0;
                    keycode   <= next_keycode;
                    key_event <= (next_keycode != keycode);
                end
            end
        end
    end

endmodule
